// File: rtl/mesh_pkt_pkg.sv
// Shared definitions for the mesh packet driver: packet field offsets, command
// modes, FSM states, terminal placement and the LFSR step.
package mesh_pkt_pkg;

    localparam int NXT_JUMP_W = 8;
    localparam int ROW_W      = 4;
    localparam int COL_W      = 4;
    // Offsets are counted down from the packet MSB so they hold for any pckg_sz.
    localparam int ROW_OFS    = 8;
    localparam int COL_OFS    = 12;
    localparam int MODE_OFS   = 16;
    localparam int HDR_W      = 17;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        MODE_RANDOM     = 2'd0,
        MODE_FIXED_SRC  = 2'd1,
        MODE_FIXED_DEST = 2'd2,
        MODE_FIXED_BOTH = 2'd3
    } cmd_mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_GEN  = 1'b1
    } gen_state_e;

    // Terminals ring the mesh: top edge, left edge, bottom edge, right edge.
    function automatic logic [7:0] term_pos(input logic [7:0] idx, input int rows, input int cols);
        int i;
        int r;
        int c;
        i = int'(idx);
        if (i < cols) begin
            r = 0;
            c = i + 1;
        end else if (i < cols + rows) begin
            r = i - cols + 1;
            c = 0;
        end else if (i < 2 * cols + rows) begin
            r = rows + 1;
            c = i - cols - rows + 1;
        end else begin
            r = i - 2 * cols - rows + 1;
            c = cols + 1;
        end
        return {4'(r), 4'(c)};
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/mesh_pkt_driver_term_fifo.sv
// Per-terminal packet FIFO; head is presented combinationally and reads as zero
// when the FIFO is empty.
module term_fifo #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [pckg_sz-1:0] data_in,
    output logic               full,
    output logic               pndng,
    output logic [pckg_sz-1:0] data_out
);

    localparam int AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int CW = $clog2(fifo_depth + 1);
    localparam logic [AW-1:0] LAST  = AW'(fifo_depth - 1);
    localparam logic [CW-1:0] DEPTH = CW'(fifo_depth);

    logic [pckg_sz-1:0] mem_q [fifo_depth];
    logic [pckg_sz-1:0] mem_d [fifo_depth];
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               do_push_s;
    logic               do_pop_s;

    always_comb begin
        do_pop_s  = pop && (count_q != '0);
        do_push_s = push && (count_q != DEPTH);
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
        end
        if (do_pop_s) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + AW'(1);
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < fifo_depth; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full     = (count_q == DEPTH);
    assign pndng    = (count_q != '0);
    assign data_out = pndng ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/mesh_pkt_driver.sv
// Mesh packet driver: generates addressed packets into per-terminal FIFOs.
// Define SENT_MON_EN to add the registered sent_valid/sent_term/sent_data monitor.
module mesh_pkt_driver
    import mesh_pkt_pkg::*;
#(
    parameter int          ROWS       = 4,
    parameter int          COLUMS     = 4,
    parameter int          pckg_sz    = 40,
    parameter int          fifo_depth = 4,
    parameter logic [31:0] SEED       = 32'h1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        cmd_valid,
    output logic                                        cmd_ready,
    input  logic [1:0]                                  cmd_mode,
    input  logic [7:0]                                  cmd_count,
    input  logic [7:0]                                  cmd_src,
    input  logic [3:0]                                  cmd_row,
    input  logic [3:0]                                  cmd_col,
    output logic [(2*ROWS+2*COLUMS)-1:0]                pndng_i_in,
    output logic [(2*ROWS+2*COLUMS)*pckg_sz-1:0]        data_out_i_in,
    input  logic [(2*ROWS+2*COLUMS)-1:0]                popin,
    output logic                                        busy
`ifdef SENT_MON_EN
    ,
    output logic                                        sent_valid,
    output logic [7:0]                                  sent_term,
    output logic [pckg_sz-1:0]                          sent_data
`endif
);

    localparam int DRVRS = 2 * ROWS + 2 * COLUMS;
    localparam int PAY_W = pckg_sz - HDR_W;

    gen_state_e         state_q, state_d;
    cmd_mode_e          mode_q, mode_d;
    logic [7:0]         count_q, count_d;
    logic [7:0]         src_q, src_d;
    logic [3:0]         row_q, row_d;
    logic [3:0]         col_q, col_d;
    logic [31:0]        lfsr_q, lfsr_d;

    logic [7:0]         sel_src_s;
    logic [7:0]         src_pos_s;
    logic [7:0]         dest_s;
    logic [pckg_sz-1:0] pkt_s;
    logic               src_full_s;
    logic               do_push_s;
    logic [DRVRS-1:0]   push_s;
    logic [DRVRS-1:0]   full_s;

    // Source/destination selection and packet assembly for the current GEN cycle.
    always_comb begin
        case (mode_q)
            MODE_FIXED_SRC, MODE_FIXED_BOTH: sel_src_s = src_q;
            default:                         sel_src_s = 8'(lfsr_q % 32'(DRVRS));
        endcase
        src_pos_s = term_pos(sel_src_s, ROWS, COLUMS);
        case (mode_q)
            MODE_FIXED_DEST, MODE_FIXED_BOTH: dest_s = {row_q, col_q};
            default: dest_s = term_pos(8'((lfsr_q >> 8) % 32'(DRVRS)), ROWS, COLUMS);
        endcase
        if (dest_s == src_pos_s) begin
            dest_s = term_pos(8'((32'(sel_src_s) + 32'd1) % 32'(DRVRS)), ROWS, COLUMS);
        end else begin
            dest_s = dest_s;
        end
        pkt_s                                = '0;
        pkt_s[pckg_sz-1-ROW_OFS -: ROW_W]    = dest_s[7:4];
        pkt_s[pckg_sz-1-COL_OFS -: COL_W]    = dest_s[3:0];
        pkt_s[pckg_sz-1-MODE_OFS]            = lfsr_q[0];
        pkt_s[PAY_W-1:0]                     = PAY_W'(lfsr_q);
        src_full_s                           = 1'b0;
        for (int i = 0; i < DRVRS; i++) begin
            if (sel_src_s == 8'(i)) begin
                src_full_s = src_full_s | full_s[i];
            end else begin
                src_full_s = src_full_s;
            end
        end
    end

    // Command FSM: latch on handshake, push one packet per non-stalled GEN cycle.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        count_d   = count_q;
        src_d     = src_q;
        row_d     = row_q;
        col_d     = col_q;
        lfsr_d    = lfsr_q;
        do_push_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    mode_d  = cmd_mode_e'(cmd_mode);
                    count_d = cmd_count;
                    src_d   = 8'(32'(cmd_src) % 32'(DRVRS));
                    row_d   = cmd_row;
                    col_d   = cmd_col;
                    state_d = S_GEN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GEN: begin
                if (count_q == 8'd0) begin
                    state_d = S_IDLE;
                end else if (!src_full_s) begin
                    do_push_s = 1'b1;
                    count_d   = count_q - 8'd1;
                    lfsr_d    = lfsr_step(lfsr_q);
                    state_d   = (count_q == 8'd1) ? S_IDLE : S_GEN;
                end else begin
                    state_d = S_GEN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        for (int i = 0; i < DRVRS; i++) begin
            push_s[i] = do_push_s && (sel_src_s == 8'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_RANDOM;
            count_q <= 8'd0;
            src_q   <= 8'd0;
            row_q   <= 4'd0;
            col_q   <= 4'd0;
            lfsr_q  <= SEED;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            src_q   <= src_d;
            row_q   <= row_d;
            col_q   <= col_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE) && !reset;
    assign busy      = (state_q == S_GEN);

    for (genvar g = 0; g < DRVRS; g++) begin : g_term
        term_fifo #(
            .pckg_sz    (pckg_sz),
            .fifo_depth (fifo_depth)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (push_s[g]),
            .pop      (popin[g]),
            .data_in  (pkt_s),
            .full     (full_s[g]),
            .pndng    (pndng_i_in[g]),
            .data_out (data_out_i_in[g*pckg_sz +: pckg_sz])
        );
    end

`ifdef SENT_MON_EN
    logic               sent_valid_q, sent_valid_d;
    logic [7:0]         sent_term_q, sent_term_d;
    logic [pckg_sz-1:0] sent_data_q, sent_data_d;

    // One report port: when several terminals pop together the lowest index is reported.
    always_comb begin
        sent_valid_d = 1'b0;
        sent_term_d  = 8'd0;
        sent_data_d  = '0;
        for (int i = DRVRS - 1; i >= 0; i--) begin
            if (popin[i] && pndng_i_in[i]) begin
                sent_valid_d = 1'b1;
                sent_term_d  = 8'(i);
                sent_data_d  = data_out_i_in[i*pckg_sz +: pckg_sz];
            end else begin
                sent_valid_d = sent_valid_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sent_valid_q <= 1'b0;
            sent_term_q  <= 8'd0;
            sent_data_q  <= '0;
        end else begin
            sent_valid_q <= sent_valid_d;
            sent_term_q  <= sent_term_d;
            sent_data_q  <= sent_data_d;
        end
    end

    assign sent_valid = sent_valid_q;
    assign sent_term  = sent_term_q;
    assign sent_data  = sent_data_q;
`endif

endmodule

// File: tb/tb_mesh_pkt_driver.sv
// Directed self-checking bench for mesh_pkt_driver (default 4x4 mesh, 40-bit packets).
module tb_mesh_pkt_driver;

    localparam int PW    = 40;
    localparam int DRVRS = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_mode;
    logic [7:0]            cmd_count;
    logic [7:0]            cmd_src;
    logic [3:0]            cmd_row;
    logic [3:0]            cmd_col;
    logic [DRVRS-1:0]      pndng_i_in;
    logic [DRVRS*PW-1:0]   data_out_i_in;
    logic [DRVRS-1:0]      popin;
    logic                  busy;
`ifdef SENT_MON_EN
    logic                  sent_valid;
    logic [7:0]            sent_term;
    logic [PW-1:0]         sent_data;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    mesh_pkt_driver dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_mode      (cmd_mode),
        .cmd_count     (cmd_count),
        .cmd_src       (cmd_src),
        .cmd_row       (cmd_row),
        .cmd_col       (cmd_col),
        .pndng_i_in    (pndng_i_in),
        .data_out_i_in (data_out_i_in),
        .popin         (popin),
        .busy          (busy)
`ifdef SENT_MON_EN
        ,
        .sent_valid    (sent_valid),
        .sent_term     (sent_term),
        .sent_data     (sent_data)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_pos(input int t);
        case (t)
            0: return 8'h01;  1: return 8'h02;  2: return 8'h03;  3: return 8'h04;
            4: return 8'h10;  5: return 8'h20;  6: return 8'h30;  7: return 8'h40;
            8: return 8'h51;  9: return 8'h52; 10: return 8'h53; 11: return 8'h54;
            12: return 8'h15; 13: return 8'h25; 14: return 8'h35; 15: return 8'h45;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic bit is_term_pos(input logic [7:0] d);
        for (int t = 0; t < DRVRS; t++) begin
            if (exp_pos(t) == d) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [PW-1:0] head(input int t);
        return data_out_i_in[t*PW +: PW];
    endfunction

    task automatic do_reset(input int n);
        reset     = 1'b1;
        cmd_valid = 1'b0;
        popin     = '0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic issue(input logic [1:0] m, input logic [7:0] cnt, input logic [7:0] s,
                         input logic [3:0] r, input logic [3:0] c);
        cmd_mode  = m;
        cmd_count = cnt;
        cmd_src   = s;
        cmd_row   = r;
        cmd_col   = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        popin     = '0;
        repeat (5) @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready);
        end
        tests_run++;
        if (pndng_i_in !== 16'h0000 || data_out_i_in !== '0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: pndng %h busy %b expected pndng 0000 busy 0", pndng_i_in, busy);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_fixed_both();
        logic [PW-1:0] exp_pkt [3];
        bit ok;
        exp_pkt[0] = 40'h00_5280_0001;
        exp_pkt[1] = 40'h00_52A0_0003;
        exp_pkt[2] = 40'h00_5230_0002;
        do_reset(2);
        issue(2'd3, 8'd3, 8'd0, 4'd5, 4'd2);
        wait_idle(50, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL fixed_both_done: busy still %b after budget, expected 0", busy);
        end
        tests_run++;
        if (pndng_i_in !== 16'h0001) begin
            tests_failed++;
            $display("FAIL fixed_both_pndng: got %h expected 0001", pndng_i_in);
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (head(0) !== exp_pkt[k]) begin
                tests_failed++;
                $display("FAIL fixed_both_pkt%0d: got %h expected %h", k, head(0), exp_pkt[k]);
            end
            popin = 16'h0001;
            @(negedge clk);
            popin = '0;
        end
        tests_run++;
        if (pndng_i_in !== 16'h0000 || head(0) !== 40'h0) begin
            tests_failed++;
            $display("FAIL fixed_both_drained: pndng %h head %h expected 0000 and 0", pndng_i_in, head(0));
        end
    endtask

    task automatic test_self_dest();
        bit ok;
        do_reset(2);
        issue(2'd3, 8'd1, 8'd0, 4'd0, 4'd1);
        wait_idle(20, ok);
        tests_run++;
        if (!ok || head(0) !== 40'h00_0280_0001) begin
            tests_failed++;
            $display("FAIL self_dest: got %h expected 0002800001", head(0));
        end
    endtask

    task automatic test_fixed_dest();
        bit ok;
        do_reset(2);
        issue(2'd2, 8'd1, 8'd0, 4'd3, 4'd3);
        wait_idle(20, ok);
        tests_run++;
        if (!ok || pndng_i_in !== 16'h0002 || head(1) !== 40'h00_3380_0001) begin
            tests_failed++;
            $display("FAIL fixed_dest: pndng %h head1 %h expected 0002 and 0033800001", pndng_i_in, head(1));
        end
    endtask

    task automatic test_src_wrap();
        bit ok;
        do_reset(2);
        issue(2'd3, 8'd1, 8'd17, 4'd5, 4'd2);
        wait_idle(20, ok);
        tests_run++;
        if (!ok || pndng_i_in !== 16'h0002 || head(1) !== 40'h00_5280_0001) begin
            tests_failed++;
            $display("FAIL src_wrap: pndng %h head1 %h expected 0002 and 0052800001", pndng_i_in, head(1));
        end
    endtask

    task automatic test_stall();
        bit ok;
        do_reset(2);
        issue(2'd1, 8'd6, 8'd4, 4'd0, 4'd0);
        repeat (20) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || pndng_i_in !== 16'h0010) begin
            tests_failed++;
            $display("FAIL stall_full: busy %b pndng %h expected 1 and 0010", busy, pndng_i_in);
        end
        tests_run++;
        if (head(4) !== 40'h00_0180_0001) begin
            tests_failed++;
            $display("FAIL stall_head: got %h expected 0001800001", head(4));
        end
        popin = 16'h0010;
        @(negedge clk);
        popin = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_one_left: busy %b expected 1", busy);
        end
        popin = 16'h0010;
        @(negedge clk);
        popin = '0;
        wait_idle(10, ok);
        tests_run++;
        if (!ok || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_finish: busy %b ready %b expected 0 and 1", busy, cmd_ready);
        end
        for (int k = 0; k < 4; k++) begin
            popin = 16'h0010;
            @(negedge clk);
        end
        popin = '0;
        tests_run++;
        if (pndng_i_in !== 16'h0000) begin
            tests_failed++;
            $display("FAIL stall_total: pndng %h after 4 more pops, expected 0000", pndng_i_in);
        end
    endtask

    task automatic test_random();
        int popped = 0;
        bit done = 1'b0;
        logic [PW-1:0] pkt;
        logic [7:0] d;
        do_reset(2);
        popin = '1;
        issue(2'd0, 8'd200, 8'd0, 4'd0, 4'd0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int t = 0; t < DRVRS; t++) begin
                if (pndng_i_in[t]) begin
                    popped++;
                    pkt = head(t);
                    d   = pkt[31:24];
                    tests_run++;
                    if (d === exp_pos(t) || !is_term_pos(d) || pkt[39:32] !== 8'h00) begin
                        tests_failed++;
                        $display("FAIL random_dest: term %0d packet %h, self pos %h", t, pkt, exp_pos(t));
                    end
                end
            end
            if (!busy && pndng_i_in == '0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        popin = '0;
        tests_run++;
        if (!done || popped != 200) begin
            tests_failed++;
            $display("FAIL random_count: popped %0d done %b expected 200 and 1", popped, done);
        end
    endtask

    task automatic test_zero_count();
        bit ok = 1'b0;
        do_reset(2);
        issue(2'd3, 8'd0, 8'd0, 4'd5, 4'd2);
        for (int i = 0; i < 2; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!busy) ok = 1'b1;
        tests_run++;
        if (!ok || pndng_i_in !== 16'h0000) begin
            tests_failed++;
            $display("FAIL zero_count: busy %b pndng %h expected 0 and 0000", busy, pndng_i_in);
        end
    endtask

    task automatic test_reset_mid_gen();
        do_reset(2);
        issue(2'd1, 8'd10, 8'd4, 4'd0, 4'd0);
        repeat (2) @(negedge clk);
        tests_run++;
        if (pndng_i_in !== 16'h0010 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_gen_pre: pndng %h busy %b expected 0010 and 1", pndng_i_in, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (pndng_i_in !== 16'h0000 || data_out_i_in !== '0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_gen_reset: pndng %h busy %b expected 0000 and 0", pndng_i_in, busy);
        end
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b1 || pndng_i_in !== 16'h0000) begin
            tests_failed++;
            $display("FAIL mid_gen_after: ready %b pndng %h expected 1 and 0000", cmd_ready, pndng_i_in);
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        cmd_count = 8'd0;
        cmd_src   = 8'd0;
        cmd_row   = 4'd0;
        cmd_col   = 4'd0;
        popin     = '0;
        test_reset();
        test_fixed_both();
        test_self_dest();
        test_fixed_dest();
        test_src_wrap();
        test_stall();
        test_random();
        test_zero_count();
        test_reset_mid_gen();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
